ex_exc_unit: RTL and testbench
==============================

// Module: ex_exc_unit
// PURPOSE
//  Registered exception stage between execute and memory. Detects arithmetic exceptions on
//  add/addi/sub/mult/div and replaces the faulting instruction with setx <code>. Adds per-cause
//  masking, a sticky cause register, a saturating exception counter, a timed younger-instruction
//  flush and an exc_req/exc_ack handshake to the status/writeback logic.
// PARAMETERS
//  NUM_SRC       5         number of exception causes (cause codes 1..NUM_SRC)
//  FLUSH_CYCLES  2         cycles of flush after a raised exception (0..15; 0 = no flush phase)
//  CNT_W         8         width of exc_count
//  SETX_OPC      5'b10101  opcode placed in ir_out[31:27] for setx
// PORTS
//  clock           in   1         sole clock, rising edge
//  reset           in   1         synchronous, active-high
//  stall           in   1         downstream stall; all registered state holds
//  in_valid        in   1         ir_in carries a real instruction
//  ir_in           in   32        instruction from execute
//  alu_ovf         in   1         ALU overflow (add/addi/sub)
//  data_exception  in   1         mult/div unit exception
//  mask_we         in   1         write mask_in into the mask register
//  mask_in         in   NUM_SRC   1 = cause enabled
//  cause_clr       in   1         clear the sticky cause register
//  exc_ack         in   1         status logic has consumed exc_code
//  ir_out          out  32        registered instruction (setx or pass-through)
//  out_valid       out  1         ir_out is valid
//  hold            out  1         upstream must stall (FLUSH/WAIT_ACK)
//  flush           out  1         squash younger in-flight instructions
//  exc_req         out  1         exception pending acknowledgement
//  exc_code        out  3         code of the pending exception
//  cause           out  NUM_SRC   sticky cause bits, bit k-1 = code k
//  exc_count       out  CNT_W     raised exceptions, saturating
// BEHAVIOUR
//  Reset: all outputs 0, mask = all ones, FSM = IDLE.
//  Decode: opcode = ir_in[31:27], alu_op = ir_in[6:2]. Codes: add(op 0, alu 0, alu_ovf)=1,
//   addi(op 5, alu_ovf)=2, sub(op 0, alu 1, alu_ovf)=3, mult(op 0, alu 6, data_exception)=4,
//   div(op 0, alu 7, data_exception)=5. alu_ovf ignored for mult/div, data_exception ignored
//   for add/addi/sub. Causes are mutually exclusive. hit = in_valid & match & mask[code-1].
//  Latency 1 cycle. stall=1: no register or FSM state changes, handshake outputs held.
//  IDLE (hold=0): ir_out<=ir_in, out_valid<=in_valid. On hit: ir_out<={SETX_OPC, 27'(code)},
//   cause[code-1]<=1, exc_count++ (saturates at all ones), exc_code<=code, then go to FLUSH with
//   cnt=FLUSH_CYCLES, or to WAIT_ACK with exc_req=1 when FLUSH_CYCLES=0.
//  FLUSH: flush=1, hold=1, out_valid<=0, ir_in ignored; cnt decrements; when cnt reaches 1, go to
//   WAIT_ACK with flush<=0 and exc_req<=1. flush is high for exactly FLUSH_CYCLES cycles.
//  WAIT_ACK: exc_req=1, hold=1, out_valid<=0, exc_code stable; exc_ack -> IDLE, exc_req<=0,
//   hold<=0 the next cycle. exc_ack outside WAIT_ACK is ignored.
//  Masked exception: instruction passes unchanged; no cause bit set, no count, no state change.
//  mask_we takes effect the next cycle; a same-cycle decode uses the old mask.
//  cause_clr together with a new hit: the new bit ends set, all other bits clear.
//  Reset in any state: immediate IDLE with reset values; no partial handshake persists.
// STRUCTURE
//  exc_defs.vh (shared): opcode/alu_op constants, SETX_OPC, cause code localparams 1..5, FSM
//   state encoding (IDLE/FLUSH/WAIT_ACK).
//  Sub-module exc_decode: combinational (ir, alu_ovf, data_exception, mask) -> hit, code[2:0].
//  Top level: FSM, flush counter, ir/valid pipeline register, cause/mask/count registers.
// TESTING
//  add (op 0, alu 0), alu_ovf=1 -> next cycle ir_out=32'hA8000001, cause=5'b00001, count=1,
//   flush high for 2 cycles, then exc_req=1, exc_code=1.
//  div, data_exception=1, then 5 cycles without exc_ack -> exc_req/hold stay 1, out_valid=0;
//   exc_ack -> IDLE, ir_out=32'hA8000005 seen once only.
//  mask_in=5'b11101, addi with alu_ovf -> ir_out=ir_in unchanged, cause=0, count=0, hold=0.
//  mult with alu_ovf=1, data_exception=0 -> pass-through, no exception.
//  cause_clr with a sub overflow in the same cycle -> cause=5'b00100.
//  CNT_W=2, 4 acked exceptions -> exc_count stays 3.
//  reset asserted mid-FLUSH -> all outputs 0 next cycle, mask=all ones.
//  stall high during FLUSH -> flush length extends by the number of stalled cycles.

Source files
------------

// File: rtl/ex_exc_unit_pkg.sv
// Shared definitions for the execute-stage exception unit: instruction field
// constants, cause codes, the setx encoding and the FSM state type.
package ex_exc_unit_pkg;

  // Major opcodes (ir[31:27]) and ALU function codes (ir[6:2])
  localparam logic [4:0] OPC_ALU  = 5'd0;
  localparam logic [4:0] OPC_ADDI = 5'd5;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_MULT = 5'd6;
  localparam logic [4:0] ALU_DIV  = 5'd7;

  // Opcode of the setx instruction that replaces a faulting instruction
  localparam logic [4:0] SETX_OPC_DEF = 5'b10101;

  // Cause codes; code k maps to cause/mask bit k-1
  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_ADD  = 3'd1;
  localparam logic [2:0] CODE_ADDI = 3'd2;
  localparam logic [2:0] CODE_SUB  = 3'd3;
  localparam logic [2:0] CODE_MULT = 3'd4;
  localparam logic [2:0] CODE_DIV  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  // setx <code>: opcode in the top five bits, zero-extended code below
  function automatic logic [31:0] make_setx(input logic [4:0] opc, input logic [2:0] code);
    return {opc, 24'd0, code};
  endfunction

endpackage

// File: rtl/ex_exc_unit_decode.sv
// Combinational exception decoder: maps the instruction fields and the unit
// exception flags to a cause code, its one-hot cause bit and a masked hit.
module exc_decode
  import ex_exc_unit_pkg::*;
#(
  parameter int NUM_SRC = 5
) (
  input  logic [4:0]         opcode,
  input  logic [4:0]         alu_op,
  input  logic               alu_ovf,
  input  logic               data_exception,
  input  logic [NUM_SRC-1:0] mask,
  output logic               hit,
  output logic [2:0]         code,
  output logic [NUM_SRC-1:0] code_bit
);

  // Select the cause code, then derive the one-hot bit and the mask-qualified hit
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    code     = CODE_NONE;
    code_bit = '0;
    if (opcode == OPC_ADDI) begin
      if (alu_ovf) code = CODE_ADDI;
    end else if (opcode == OPC_ALU) begin
      case (alu_op)
        ALU_ADD:  if (alu_ovf)        code = CODE_ADD;
        ALU_SUB:  if (alu_ovf)        code = CODE_SUB;
        ALU_MULT: if (data_exception) code = CODE_MULT;
        ALU_DIV:  if (data_exception) code = CODE_DIV;
        default:  code = CODE_NONE;
      endcase
    end
    if (code != CODE_NONE) code_bit = NUM_SRC'(1) << (code - 3'd1);
    hit = |(code_bit & mask);
  end

endmodule

// File: rtl/ex_exc_unit.sv
// Registered exception stage between execute and memory. A faulting
// instruction is replaced by setx <code>, younger instructions are flushed for
// a fixed number of cycles, and the exception is then held on exc_req until
// the status logic acknowledges it.
module ex_exc_unit
  import ex_exc_unit_pkg::*;
#(
  parameter int         NUM_SRC      = 5,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         CNT_W        = 8,
  parameter logic [4:0] SETX_OPC     = SETX_OPC_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               in_valid,
  input  logic [31:0]        ir_in,
  input  logic               alu_ovf,
  input  logic               data_exception,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_in,
  input  logic               cause_clr,
  input  logic               exc_ack,
  output logic [31:0]        ir_out,
  output logic               out_valid,
  output logic               hold,
  output logic               flush,
  output logic               exc_req,
  output logic [2:0]         exc_code,
  output logic [NUM_SRC-1:0] cause,
  output logic [CNT_W-1:0]   exc_count
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t             state, state_d;
  logic [3:0]         cnt, cnt_d;
  logic [NUM_SRC-1:0] mask;
  logic               dec_hit;
  logic [2:0]         dec_code;
  logic [NUM_SRC-1:0] dec_bit;
  logic               raise;

  exc_decode #(.NUM_SRC(NUM_SRC)) u_decode (
    .opcode         (ir_in[31:27]),
    .alu_op         (ir_in[6:2]),
    .alu_ovf        (alu_ovf),
    .data_exception (data_exception),
    .mask           (mask),
    .hit            (dec_hit),
    .code           (dec_code),
    .code_bit       (dec_bit)
  );

  // An exception is only taken for a valid instruction while accepting input
  assign raise = in_valid && dec_hit && (state == ST_IDLE);

  // Next-state and flush counter logic; handshake outputs decode the current state
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    flush   = 1'b0;
    hold    = 1'b0;
    exc_req = 1'b0;
    case (state)
      ST_IDLE: begin
        if (raise) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = ST_WAIT_ACK;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        hold  = 1'b1;
        if (cnt <= 4'd1) state_d = ST_WAIT_ACK;
        else             cnt_d   = cnt - 4'd1;
      end
      ST_WAIT_ACK: begin
        hold    = 1'b1;
        exc_req = 1'b1;
        if (exc_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipeline, FSM and status registers; stall freezes everything
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ir_out    <= '0;
      out_valid <= 1'b0;
      exc_code  <= '0;
      cause     <= '0;
      exc_count <= '0;
      mask      <= '1;
    end else if (!stall) begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == ST_IDLE) begin
        out_valid <= in_valid;
        ir_out    <= raise ? make_setx(SETX_OPC, dec_code) : ir_in;
      end else begin
        out_valid <= 1'b0;
      end
      if (raise) begin
        exc_code <= dec_code;
        if (exc_count != '1) exc_count <= exc_count + CNT_W'(1);
      end
      cause <= (cause_clr ? '0 : cause) | (raise ? dec_bit : '0);
      if (mask_we) mask <= mask_in;
    end
  end

endmodule

// File: tb/tb_ex_exc_unit.sv
// Directed bench for ex_exc_unit. Expected ir_out values are queued when an
// instruction is accepted and popped when out_valid is seen. A second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_ex_exc_unit;
  import ex_exc_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset, stall, in_valid, alu_ovf, data_exception;
  logic        mask_we, cause_clr, exc_ack;
  logic [31:0] ir_in;
  logic [4:0]  mask_in;

  logic [31:0] ir_out, s_ir_out;
  logic        out_valid, hold, flush, exc_req;
  logic        s_out_valid, s_hold, s_flush, s_exc_req;
  logic [2:0]  exc_code, s_exc_code;
  logic [4:0]  cause, s_cause;
  logic [7:0]  exc_count;
  logic [1:0]  s_exc_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic [31:0] ir;
  int          fl, n;

  ex_exc_unit u_dut (
    .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid), .ir_in(ir_in),
    .alu_ovf(alu_ovf), .data_exception(data_exception), .mask_we(mask_we),
    .mask_in(mask_in), .cause_clr(cause_clr), .exc_ack(exc_ack),
    .ir_out(ir_out), .out_valid(out_valid), .hold(hold), .flush(flush),
    .exc_req(exc_req), .exc_code(exc_code), .cause(cause), .exc_count(exc_count)
  );

  ex_exc_unit #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid), .ir_in(ir_in),
    .alu_ovf(alu_ovf), .data_exception(data_exception), .mask_we(mask_we),
    .mask_in(mask_in), .cause_clr(cause_clr), .exc_ack(exc_ack),
    .ir_out(s_ir_out), .out_valid(s_out_valid), .hold(s_hold), .flush(s_flush),
    .exc_req(s_exc_req), .exc_code(s_exc_code), .cause(s_cause), .exc_count(s_exc_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge, scoreboard popped on out_valid
  task automatic tick();
    logic live;
    live = !stall && !reset;
    @(posedge clock);
    #1;
    if (live && out_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      else                check("ir_out", ir_out, sb.pop_front());
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] alu);
    logic [19:0] f;
    f = 20'($urandom);
    return {op, f, alu, 2'b11};
  endfunction

  task automatic drive(input logic [31:0] i, input logic ovf, input logic dex,
                       input logic [31:0] expv);
    in_valid       = 1'b1;
    ir_in          = i;
    alu_ovf        = ovf;
    data_exception = dex;
    sb.push_back(expv);
    tick();
    in_valid       = 1'b0;
    alu_ovf        = 1'b0;
    data_exception = 1'b0;
    ir_in          = $urandom;
  endtask

  // Wait (bounded) for exc_req, check the code, then acknowledge
  task automatic finish_exc(input logic [2:0] code);
    int k;
    k = 0;
    while (exc_req !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check("exc_req_rise", {31'd0, exc_req}, 32'd1);
    check("exc_code", {29'd0, exc_code}, {29'd0, code});
    check("hold_wait", {31'd0, hold}, 32'd1);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    check("exc_req_acked", {31'd0, exc_req}, 32'd0);
    check("hold_acked", {31'd0, hold}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; in_valid = 1'b0; ir_in = '0; alu_ovf = 1'b0;
    data_exception = 1'b0; mask_we = 1'b0; mask_in = '0; cause_clr = 1'b0; exc_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_ir_out", ir_out, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hold", {31'd0, hold}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_exc_req", {31'd0, exc_req}, 32'd0);
    check("rst_exc_code", {29'd0, exc_code}, 32'd0);
    check("rst_cause", {27'd0, cause}, 32'd0);
    check("rst_count", {24'd0, exc_count}, 32'd0);

    // Non-exception ALU op passes even with both flags set
    ir = mk(OPC_ALU, 5'd2);
    drive(ir, 1'b1, 1'b1, ir);
    check("pass_hold", {31'd0, hold}, 32'd0);

    // add overflow: setx 1, flush for two cycles, then request
    drive(mk(OPC_ALU, ALU_ADD), 1'b1, 1'b0, 32'hA800_0001);
    check("add_cause", {27'd0, cause}, 32'h01);
    check("add_count", {24'd0, exc_count}, 32'd1);
    check("add_flush1", {31'd0, flush}, 32'd1);
    check("add_hold", {31'd0, hold}, 32'd1);
    check("add_req_early", {31'd0, exc_req}, 32'd0);
    tick();
    check("add_flush2", {31'd0, flush}, 32'd1);
    check("add_req_early2", {31'd0, exc_req}, 32'd0);
    tick();
    check("add_flush_end", {31'd0, flush}, 32'd0);
    check("add_req", {31'd0, exc_req}, 32'd1);
    finish_exc(CODE_ADD);

    // exc_ack outside WAIT_ACK has no effect
    exc_ack = 1'b1;
    ir = mk(OPC_ADDI, 5'd9);
    drive(ir, 1'b0, 1'b0, ir);
    exc_ack = 1'b0;
    check("stray_ack_req", {31'd0, exc_req}, 32'd0);
    check("stray_ack_hold", {31'd0, hold}, 32'd0);

    // div exception held without acknowledgement
    drive(mk(OPC_ALU, ALU_DIV), 1'b0, 1'b1, 32'hA800_0005);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("div_req_held", {31'd0, exc_req}, 32'd1);
      check("div_hold_held", {31'd0, hold}, 32'd1);
      check("div_out_valid", {31'd0, out_valid}, 32'd0);
      check("div_code_held", {29'd0, exc_code}, 32'd5);
    end
    finish_exc(CODE_DIV);
    check("div_cause", {27'd0, cause}, 32'h11);
    check("div_count", {24'd0, exc_count}, 32'd2);

    // cause_clr together with a sub overflow leaves only the new bit
    cause_clr = 1'b1;
    drive(mk(OPC_ALU, ALU_SUB), 1'b1, 1'b0, 32'hA800_0003);
    cause_clr = 1'b0;
    check("clr_cause", {27'd0, cause}, 32'h04);
    check("clr_count", {24'd0, exc_count}, 32'd3);
    finish_exc(CODE_SUB);

    // mult ignores alu_ovf, add ignores data_exception
    ir = mk(OPC_ALU, ALU_MULT);
    drive(ir, 1'b1, 1'b0, ir);
    check("mult_ovf_hold", {31'd0, hold}, 32'd0);
    ir = mk(OPC_ALU, ALU_ADD);
    drive(ir, 1'b0, 1'b1, ir);
    check("add_dex_hold", {31'd0, hold}, 32'd0);
    check("ignored_count", {24'd0, exc_count}, 32'd3);

    // Fourth exception: wide counter reads 4, 2-bit counter saturates at 3
    drive(mk(OPC_ADDI, 5'($urandom)), 1'b1, 1'b0, 32'hA800_0002);
    check("addi_cause", {27'd0, cause}, 32'h06);
    check("count_4", {24'd0, exc_count}, 32'd4);
    check("sat_count", {30'd0, s_exc_count}, 32'd3);
    finish_exc(CODE_ADDI);

    // Mask write in the same cycle as an addi overflow: old mask still applies
    mask_we = 1'b1;
    mask_in = 5'b11101;
    drive(mk(OPC_ADDI, 5'($urandom)), 1'b1, 1'b0, 32'hA800_0002);
    mask_we = 1'b0;
    check("oldmask_count", {24'd0, exc_count}, 32'd5);
    check("oldmask_flush", {31'd0, flush}, 32'd1);
    finish_exc(CODE_ADDI);

    // addi now masked: passes unchanged, no state change
    ir = mk(OPC_ADDI, 5'($urandom));
    drive(ir, 1'b1, 1'b0, ir);
    check("masked_hold", {31'd0, hold}, 32'd0);
    check("masked_flush", {31'd0, flush}, 32'd0);
    check("masked_cause", {27'd0, cause}, 32'h06);
    check("masked_count", {24'd0, exc_count}, 32'd5);

    // Stall during FLUSH stretches the flush by the stalled cycles
    drive(mk(OPC_ALU, ALU_SUB), 1'b1, 1'b0, 32'hA800_0003);
    check("stall_flush_start", {31'd0, flush}, 32'd1);
    stall = 1'b1;
    repeat (3) begin
      tick();
      check("stall_flush_held", {31'd0, flush}, 32'd1);
    end
    stall = 1'b0;
    fl = 4;
    n  = 0;
    do begin
      tick();
      n++;
      if (flush === 1'b1) fl++;
    end while (flush === 1'b1 && n < 20);
    check("flush_len_stalled", fl, 32'd5);
    stall   = 1'b1;
    exc_ack = 1'b1;
    tick();
    check("stalled_ack_ignored", {31'd0, exc_req}, 32'd1);
    exc_ack = 1'b0;
    stall   = 1'b0;
    finish_exc(CODE_SUB);

    // Exception presented while stalled in IDLE is not taken
    stall    = 1'b1;
    in_valid = 1'b1;
    ir_in    = mk(OPC_ALU, ALU_ADD);
    alu_ovf  = 1'b1;
    tick();
    in_valid = 1'b0;
    alu_ovf  = 1'b0;
    stall    = 1'b0;
    check("stall_idle_count", {24'd0, exc_count}, 32'd6);
    check("stall_idle_hold", {31'd0, hold}, 32'd0);

    // Reset in the middle of FLUSH
    drive(mk(OPC_ALU, ALU_ADD), 1'b1, 1'b0, 32'hA800_0001);
    tick();
    check("pre_reset_flush", {31'd0, flush}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ir_out", ir_out, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_hold", {31'd0, hold}, 32'd0);
    check("mid_rst_flush", {31'd0, flush}, 32'd0);
    check("mid_rst_exc_req", {31'd0, exc_req}, 32'd0);
    check("mid_rst_exc_code", {29'd0, exc_code}, 32'd0);
    check("mid_rst_cause", {27'd0, cause}, 32'd0);
    check("mid_rst_count", {24'd0, exc_count}, 32'd0);

    // Mask is back to all ones: addi overflow raises again
    drive(mk(OPC_ADDI, 5'($urandom)), 1'b1, 1'b0, 32'hA800_0002);
    check("post_rst_cause", {27'd0, cause}, 32'h02);
    check("post_rst_count", {24'd0, exc_count}, 32'd1);
    finish_exc(CODE_ADDI);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
